tap_controller: RTL and testbench
=================================

Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine plus instruction register (IR) for the debug/test port.
- Sequences Capture/Shift/Update for the IR and for the active data register (DR).
- Holds the current instruction. `irInstruction_o` drives the IR decoder, which selects BSR or BYPASS.
- Emits per-state DR control levels and multiplexes TDO between the IR shift chain and the selected DR's serial output.

Parameters:
- IR_WIDTH, 4, instruction register width; must equal `instruction_width` in `tap_pkg`.
- IR_CAPTURE, 4'b0001, value loaded into the IR shift register in CAPTURE_IR; bits [1:0] must be 2'b01.
- IR_RESET, 4'b1111, instruction loaded on reset and in TEST_LOGIC_RESET; all-ones = BYPASS.

Ports:
- tck_i  in  1  test clock; all state is updated on the rising edge.
- trst_i  in  1  asynchronous, active-high reset.
- tms_i  in  1  test mode select.
- tdi_i  in  1  serial test data in.
- drTdo_i  in  1  serial out of the DR currently selected by the decoder (BSR or bypass).
- tdo_o  out  1  serial test data out.
- tdoEnable_o  out  1  high while in SHIFT_IR or SHIFT_DR.
- irInstruction_o  out  IR_WIDTH  current instruction, to the IR decoder.
- tapReset_o  out  1  high in TEST_LOGIC_RESET.
- captureDR_o  out  1  high in CAPTURE_DR.
- shiftDR_o  out  1  high in SHIFT_DR.
- updateDR_o  out  1  high in UPDATE_DR.
- runIdle_o  out  1  high in RUN_TEST_IDLE.
- state_o  out  4  encoded current state, for debug.

Behaviour:
- Reset: trst_i high asynchronously forces:
  - state = TEST_LOGIC_RESET,
  - irInstruction_o = IR_RESET,
  - IR shift register = IR_CAPTURE,
  - tapReset_o = 1; all other outputs 0.
- Reset released mid-scan: FSM restarts from TEST_LOGIC_RESET; partial shift data is discarded.
- State encoding for state_o:
  - TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8,
  - SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15.
- Transitions, written (next if TMS=0 / next if TMS=1):
  - TLR (RTI/TLR); RTI (RTI/SEL_DR); SEL_DR (CAP_DR/SEL_IR); CAP_DR (SH_DR/EX1_DR);
  - SH_DR (SH_DR/EX1_DR); EX1_DR (PA_DR/UPD_DR); PA_DR (PA_DR/EX2_DR); EX2_DR (SH_DR/UPD_DR); UPD_DR (RTI/SEL_DR);
  - SEL_IR (CAP_IR/TLR); IR branch mirrors the DR branch; UPD_IR (RTI/SEL_DR).
- Any state reaches TLR after at most 5 consecutive rising edges with tms_i=1.
- All state-decoded outputs are Moore: pure decode of the state register, glitch-free, no extra latency.
- IR shift register, per rising edge:
  - state=CAP_IR: load IR_CAPTURE.
  - state=SH_IR: shift right, {tdi_i, sr[IR_WIDTH-1:1]}. This includes the edge that exits to EX1_IR.
  - other states: hold.
- IR update:
  - On the rising edge where state=UPD_IR, irInstruction_o <= shift register; the new value is visible the cycle after UPD_IR.
  - On every edge where state=TLR, irInstruction_o <= IR_RESET.
  - irInstruction_o holds in all other states; pausing (PA_IR) never alters it.
- TDO:
  - SH_IR: tdo_o = sr[0].
  - SH_DR: tdo_o = drTdo_i.
  - otherwise tdo_o = 0 and tdoEnable_o = 0.
  - Combinational from state and register; no retiming.
- DR shift registers live outside this block; this block only sequences them via captureDR_o/shiftDR_o/updateDR_o.
- No X propagation: an unknown state encoding (none is possible with 4 bits) falls back to TLR.

Test Plan:
- Pulse trst_i mid-SH_IR with tms_i=0 -> immediately state_o=0, tapReset_o=1, irInstruction_o=4'b1111; next edge with tms_i=0 -> state_o=1.
- From each of the 16 states (reached by directed TMS sequences), drive tms_i=1 for 5 edges -> state_o=0. Exhaustively check all 32 state×TMS transitions against the table.
- IR load of 4'b0000:
  - Stimulus: TMS sequence 0,1,1,0,0 to reach SH_IR; shift tdi_i=0,0,0,0 with tms_i=1 on the 4th bit; then TMS 1,0.
  - Response: tdo_o serially out 1,0,0,0 (the capture value); irInstruction_o=4'b0000 from the cycle after UPD_IR.
- DR scan:
  - Stimulus: RTI, TMS 1,0,0; hold SH_DR for 8 edges; then 1,1.
  - Response: captureDR_o high exactly 1 cycle; shiftDR_o high 8 cycles plus the exit edge cycle; updateDR_o high 1 cycle; tdo_o mirrors drTdo_i only while shiftDR_o=1.
- Pause IR:
  - Stimulus: shift 2 bits, EX1_IR->PA_IR for 3 cycles, EX2_IR->SH_IR, shift 2 more, update.
  - Response: irInstruction_o equals the 4 shifted bits; it is unchanged throughout the pause.
- TLR reset: with irInstruction_o=4'b0000, 5×tms_i=1 -> irInstruction_o=4'b1111, tapReset_o=1, tdoEnable_o=0.

Source files
------------

// File: rtl/tap_controller.sv
// ---------------------------------------------------------------------------
// tap_controller
//   IEEE 1149.1 TAP state machine plus instruction register.
//   Sequences Capture/Shift/Update for the IR and for the external DR that
//   the IR decoder selects. It holds the current instruction and emits the
//   per-state DR control levels. It multiplexes TDO between the IR shift
//   chain and the selected DR's serial output.
//
// Ports
//   tck_i            test clock; all state updates on the rising edge
//   trst_i           asynchronous active-high reset
//   tms_i            test mode select
//   tdi_i            serial test data in
//   drTdo_i          serial out of the currently selected DR (BSR/bypass)
//   tdo_o            serial test data out
//   tdoEnable_o      high in SHIFT_IR or SHIFT_DR
//   irInstruction_o  current instruction, to the IR decoder
//   tapReset_o       high in TEST_LOGIC_RESET
//   captureDR_o      high in CAPTURE_DR
//   shiftDR_o        high in SHIFT_DR
//   updateDR_o       high in UPDATE_DR
//   runIdle_o        high in RUN_TEST_IDLE
//   state_o          encoded current state (debug)
//
// The state-decoded outputs are registered. They are computed from the
// next state, so each one is a plain decode of the state register with no
// extra latency and no combinational glitches.
// ---------------------------------------------------------------------------
module tap_controller #(
  parameter int unsigned           IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0]   IR_CAPTURE = 4'b0001,
  parameter logic [IR_WIDTH-1:0]   IR_RESET   = 4'b1111
) (
  input  logic                tck_i,
  input  logic                trst_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  input  logic                drTdo_i,
  output logic                tdo_o,
  output logic                tdoEnable_o,
  output logic [IR_WIDTH-1:0] irInstruction_o,
  output logic                tapReset_o,
  output logic                captureDR_o,
  output logic                shiftDR_o,
  output logic                updateDR_o,
  output logic                runIdle_o,
  output logic [3:0]          state_o
);

  // The encoding is visible on state_o, so it is fixed, not tool-chosen.
  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] irShift_q;
  logic [IR_WIDTH-1:0] irInstr_q;
  logic                tapReset_q;
  logic                captureDR_q;
  logic                shiftDR_q;
  logic                updateDR_q;
  logic                runIdle_q;
  logic                shiftIR_q;
  logic                tdoEnable_q;
  logic                tdo_d;

  // Next-state logic: the standard 16-state TAP transition table.
  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:     state_d = tms_i ? TLR    : RTI;
      RTI:     state_d = tms_i ? SEL_DR : RTI;
      SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms_i ? UPD_DR : PA_DR;
      PA_DR:   state_d = tms_i ? EX2_DR : PA_DR;
      EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
      SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms_i ? UPD_IR : PA_IR;
      PA_IR:   state_d = tms_i ? EX2_IR : PA_IR;
      EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
      // Unreachable with a full 4-bit encoding; recover to reset anyway.
      default: state_d = TLR;
    endcase
  end

  // State register plus registered Moore outputs decoded from the next state.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q     <= TLR;
      tapReset_q  <= 1'b1;
      captureDR_q <= 1'b0;
      shiftDR_q   <= 1'b0;
      updateDR_q  <= 1'b0;
      runIdle_q   <= 1'b0;
      shiftIR_q   <= 1'b0;
      tdoEnable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tapReset_q  <= (state_d == TLR);
      captureDR_q <= (state_d == CAP_DR);
      shiftDR_q   <= (state_d == SH_DR);
      updateDR_q  <= (state_d == UPD_DR);
      runIdle_q   <= (state_d == RTI);
      shiftIR_q   <= (state_d == SH_IR);
      tdoEnable_q <= (state_d == SH_DR) || (state_d == SH_IR);
    end
  end

  // IR shift chain. It keeps shifting on the edge that leaves SH_IR, so the
  // last bit clocked in with TMS=1 still lands in the register.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      irShift_q <= IR_CAPTURE;
    end else begin
      case (state_q)
        CAP_IR:  irShift_q <= IR_CAPTURE;
        SH_IR:   irShift_q <= {tdi_i, irShift_q[IR_WIDTH-1:1]};
        default: irShift_q <= irShift_q;
      endcase
    end
  end

  // Instruction latch. It changes only on UPD_IR or TLR; a pause in
  // PA_IR leaves it untouched.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      irInstr_q <= IR_RESET;
    end else begin
      case (state_q)
        UPD_IR:  irInstr_q <= irShift_q;
        TLR:     irInstr_q <= IR_RESET;
        default: irInstr_q <= irInstr_q;
      endcase
    end
  end

  // TDO mux. This path is combinational so DR data appears in the same cycle.
  always_comb begin
    tdo_d = 1'b0;
    if (shiftIR_q) begin
      tdo_d = irShift_q[0];
    end else if (shiftDR_q) begin
      tdo_d = drTdo_i;
    end else begin
      tdo_d = 1'b0;
    end
  end

  assign tdo_o           = tdo_d;
  assign tdoEnable_o     = tdoEnable_q;
  assign irInstruction_o = irInstr_q;
  assign tapReset_o      = tapReset_q;
  assign captureDR_o     = captureDR_q;
  assign shiftDR_o       = shiftDR_q;
  assign updateDR_o      = updateDR_q;
  assign runIdle_o       = runIdle_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_tap_controller.sv
module tb_tap_controller;

  logic       tck = 1'b0;
  logic       trst, tms, tdi, drtdo;
  logic       tdo, tdo_en, tap_reset, cap_dr, sh_dr, upd_dr, run_idle;
  logic [3:0] instr, state;

  tap_controller dut (
    .tck_i           (tck),
    .trst_i          (trst),
    .tms_i           (tms),
    .tdi_i           (tdi),
    .drTdo_i         (drtdo),
    .tdo_o           (tdo),
    .tdoEnable_o     (tdo_en),
    .irInstruction_o (instr),
    .tapReset_o      (tap_reset),
    .captureDR_o     (cap_dr),
    .shiftDR_o       (sh_dr),
    .updateDR_o      (upd_dr),
    .runIdle_o       (run_idle),
    .state_o         (state)
  );

  always #5 tck = ~tck;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the transition table indexed by state number, plus the
  // IR chain and instruction kept as plain integers.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  string path [16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
                       "01011", "011", "0110", "01100", "01101", "011010",
                       "0110101", "011011"};
  int ms, msr, minst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; msr = 1; minst = 15;
  endtask

  task automatic model_edge(input bit t, input bit d);
    int nsr, ninst;
    nsr = msr; ninst = minst;
    if (ms == 10) nsr = 1;
    else if (ms == 11) nsr = msr / 2 + (d ? 8 : 0);
    if (ms == 15) ninst = msr;
    else if (ms == 0) ninst = 15;
    msr = nsr; minst = ninst;
    ms = t ? nxt1[ms] : nxt0[ms];
  endtask

  task automatic check_all();
    int etdo;
    etdo = (ms == 11) ? (msr % 2) : ((ms == 4) ? int'(drtdo) : 0);
    chk("state",     state,     ms);
    chk("tapReset",  tap_reset, 32'(ms == 0));
    chk("runIdle",   run_idle,  32'(ms == 1));
    chk("captureDR", cap_dr,    32'(ms == 3));
    chk("shiftDR",   sh_dr,     32'(ms == 4));
    chk("updateDR",  upd_dr,    32'(ms == 8));
    chk("tdoEnable", tdo_en,    32'(ms == 4 || ms == 11));
    chk("tdo",       tdo,       etdo);
    chk("instr",     instr,     minst);
  endtask

  task automatic step(input bit t, input bit d);
    tms = t; tdi = d; drtdo = 1'($urandom % 2);
    @(posedge tck);
    model_edge(t, d);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic trst_pulse();
    #2 trst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("trst_state", state, 0);
    chk("trst_instr", instr, 4'b1111);
    #1 trst = 1'b0;
  endtask

  task automatic walk(input string p);
    for (int i = 0; i < p.len(); i++) step(p[i] == "1", 1'b0);
  endtask

  initial begin
    int bits, cnt_cap, cnt_sh, cnt_upd, hold;
    trst = 1'b0; tms = 1'b1; tdi = 1'b0; drtdo = 1'b0;
    model_reset();
    #1 trst = 1'b1;
    #1;
    check_all();
    #5 trst = 1'b0;

    // IR load of 0000: the capture value 0001 comes out on TDO first.
    walk("01100");
    chk("irload_tdo0", tdo, 1);
    step(1'b0, 1'b0); chk("irload_tdo1", tdo, 0);
    step(1'b0, 1'b0); chk("irload_tdo2", tdo, 0);
    step(1'b0, 1'b0); chk("irload_tdo3", tdo, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("irload_pre", instr, 4'b1111);
    step(1'b0, 1'b0);
    chk("irload_instr", instr, 4'b0000);

    // Five TMS=1 edges from RTI restore BYPASS.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tlr_instr", instr, 4'b1111);
    chk("tlr_reset", tap_reset, 1);
    chk("tlr_tdoen", tdo_en, 0);

    // DR scan: capture once, shift 8 + exit cycle, update once.
    step(1'b0, 1'b0);
    cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 3) step(i != 0 ? 1'b0 : 1'b1, 1'b0);
      else if (i < 11) step(1'b0, 1'($urandom % 2));
      else step(1'b1, 1'b0);
      cnt_cap += int'(cap_dr); cnt_sh += int'(sh_dr); cnt_upd += int'(upd_dr);
    end
    chk("dr_capture_cycles", cnt_cap, 1);
    chk("dr_shift_cycles",   cnt_sh,  9);
    chk("dr_update_cycles",  cnt_upd, 1);
    step(1'b0, 1'b0);

    // Pause IR in the middle of a 4-bit shift.
    bits = int'($urandom_range(0, 15));
    walk("1100");
    step(1'b0, 1'(bits));
    step(1'b1, 1'(bits >> 1));
    hold = int'(instr);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk("pause_hold", instr, hold);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'(bits >> 2));
    step(1'b1, 1'(bits >> 3));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("pause_instr", instr, bits);

    // Reset pulse in the middle of SH_IR.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    walk("01100");
    step(1'b0, 1'b1);
    trst_pulse();
    step(1'b0, 1'b0);
    chk("trst_then_rti", state, 1);

    // All 32 state/TMS transitions, then recovery to TLR within 5 edges.
    for (int s = 0; s < 16; s++) begin
      for (int t = 0; t < 2; t++) begin
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        walk(path[s]);
        chk("path_reach", state, s);
        step(1'(t), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("five_tms_tlr", state, 0);
      end
    end

    // Random TMS/TDI/DR traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) trst_pulse();
      else step(1'($urandom_range(0, 9) < 4), 1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
